// File: rtl/input_queue.sv
// Input word queue: debounced switch entries are pushed on a button press and
// popped onto IData when control requests an input instruction.
module input_queue #(
    parameter int IO_WIDTH   = 16,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [IO_WIDTH:0]     sw,
    input  logic                  push_button,
    input  logic                  is_input,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] IData,
    output logic                  data_valid,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = 1;
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = 1;
    localparam logic [DEPTH_LOG2:0]   CNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic                  push_q, req_q;
    logic                  push_evt, pop_evt, push_ok, pop_ok, wr_en;
    logic [DATA_WIDTH-1:0] word;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic [DATA_WIDTH-1:0] idata_q, idata_d;
    logic                  valid_q, valid_d;
    logic                  ovf_q, ovf_d, unf_q, unf_d;

    assign push_evt = push_button & ~push_q;
    assign pop_evt  = is_input & ~req_q;

    // Sign extension only when the sign-select bit is set and the value's MSB is 1.
    assign word = {{(DATA_WIDTH-IO_WIDTH){sw[IO_WIDTH] & sw[IO_WIDTH-1]}}, sw[IO_WIDTH-1:0]};

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_FULL);

    // A pop in the same cycle frees a slot, so a push into a full queue still lands.
    assign pop_ok  = pop_evt & ~empty;
    assign push_ok = push_evt & (~full | pop_ok);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        idata_d  = idata_q;
        valid_d  = 1'b0;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        wr_en    = 1'b0;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
        end else begin
            if (pop_ok) begin
                idata_d  = mem_q[rd_ptr_q];
                rd_ptr_d = rd_ptr_q + PTR_ONE;
                valid_d  = 1'b1;
            end else if (pop_evt) begin
                unf_d = 1'b1;
            end
            if (push_ok) begin
                wr_en    = 1'b1;
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else if (push_evt) begin
                ovf_d = 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            push_q   <= 1'b0;
            req_q    <= 1'b0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            idata_q  <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            push_q   <= push_button;
            req_q    <= is_input;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            idata_q  <= idata_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Storage is not reset; entries are only readable once written.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= word;
        end
    end

    assign IData      = idata_q;
    assign data_valid = valid_q;
    assign count      = count_q;
    assign overflow   = ovf_q;
    assign underflow  = unf_q;

endmodule

// File: tb/tb_input_queue.sv
// Bench for input_queue: directed scenarios plus random traffic, all outputs
// compared every cycle against a queue-based reference model.
module tb_input_queue;

    localparam int IOW   = 16;
    localparam int DW    = 32;
    localparam int DL2   = 2;
    localparam int DEPTH = 1 << DL2;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic [IOW:0]    sw = '0;
    logic            push_button = 1'b0;
    logic            is_input = 1'b0;
    logic            flush = 1'b0;
    logic [DW-1:0]   IData;
    logic            data_valid, empty, full, overflow, underflow;
    logic [DL2:0]    count;

    input_queue #(.IO_WIDTH(IOW), .DATA_WIDTH(DW), .DEPTH_LOG2(DL2)) dut (
        .clock(clock), .reset(reset), .sw(sw), .push_button(push_button),
        .is_input(is_input), .flush(flush), .IData(IData), .data_valid(data_valid),
        .empty(empty), .full(full), .count(count), .overflow(overflow), .underflow(underflow)
    );

    always #5 clock = ~clock;

    // Reference model state
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] m_idata;
    logic          m_dv, m_ovf, m_unf, m_prev_pb, m_prev_ii;
    int            checks = 0;
    int            failures = 0;

    function automatic logic [DW-1:0] make_word(input logic [IOW:0] s);
        logic [DW-1:0] w;
        w = {{(DW-IOW){1'b0}}, s[IOW-1:0]};
        if (s[IOW] && s[IOW-1]) w = w | ~((DW)'((64'd1 << IOW) - 1));
        return w;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_idata = '0; m_dv = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
        m_prev_pb = 1'b0; m_prev_ii = 1'b0;
    endtask

    task automatic model_clock(input logic pb, input logic ii, input logic fl, input logic [IOW:0] s);
        logic pe, re, pop_ok;
        pe = pb & ~m_prev_pb;
        re = ii & ~m_prev_ii;
        m_prev_pb = pb;
        m_prev_ii = ii;
        m_dv = 1'b0;
        if (fl) begin
            exp_q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            pop_ok = re && (exp_q.size() > 0);
            if (pop_ok) begin
                m_idata = exp_q.pop_front();
                m_dv = 1'b1;
            end else if (re) begin
                m_unf = 1'b1;
            end
            if (pe) begin
                if (exp_q.size() < DEPTH) exp_q.push_back(make_word(s));
                else m_ovf = 1'b1;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_all();
        chk("idata", IData, m_idata);
        chk("data_valid", DW'(data_valid), DW'(m_dv));
        chk("count", DW'(count), DW'(exp_q.size()));
        chk("empty", DW'(empty), DW'(exp_q.size() == 0));
        chk("full", DW'(full), DW'(exp_q.size() == DEPTH));
        chk("overflow", DW'(overflow), DW'(m_ovf));
        chk("underflow", DW'(underflow), DW'(m_unf));
    endtask

    // Drive inputs at the falling edge, model the rising edge, check at the next falling edge.
    task automatic step(input logic pb, input logic ii, input logic fl, input logic [IOW:0] s);
        push_button = pb; is_input = ii; flush = fl; sw = s;
        @(posedge clock);
        model_clock(pb, ii, fl, s);
        @(negedge clock);
        check_all();
    endtask

    task automatic press(input logic [IOW:0] s);
        step(1'b1, 1'b0, 1'b0, s);
        step(1'b0, 1'b0, 1'b0, s);
    endtask

    task automatic pop_one();
        step(1'b0, 1'b1, 1'b0, '0);
        step(1'b0, 1'b0, 1'b0, '0);
    endtask

    initial begin
        model_reset();
        #12;
        check_all();
        chk("reset_idata", IData, 32'h0);
        @(negedge clock);
        reset = 1'b1;

        // 1: sign/zero extension and FIFO order with one-cycle data_valid
        press(17'h0_0005);
        press(17'h1_FFFE);
        press(17'h0_8001);
        chk("t1_count", DW'(count), 32'd3);
        step(1'b0, 1'b1, 1'b0, '0);
        chk("t1_pop0", IData, 32'h0000_0005);
        chk("t1_dv0", DW'(data_valid), 32'd1);
        step(1'b0, 1'b0, 1'b0, '0);
        chk("t1_dv_drop", DW'(data_valid), 32'd0);
        pop_one();
        chk("t1_pop1", IData, 32'hFFFF_FFFE);
        pop_one();
        chk("t1_pop2", IData, 32'h0000_8001);

        // 2: held levels give one event each
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0, 17'h0_00AA);
        step(1'b0, 1'b0, 1'b0, '0);
        chk("t2_count", DW'(count), 32'd1);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, '0);
        step(1'b0, 1'b0, 1'b0, '0);
        chk("t2_count_after", DW'(count), 32'd0);
        chk("t2_idata", IData, 32'h0000_00AA);

        // 3: overflow drops the fifth word
        for (int i = 0; i < 4; i++) press(17'(16'h0100 + i));
        chk("t3_full", DW'(full), 32'd1);
        press(17'h0_1234);
        chk("t3_ovf", DW'(overflow), 32'd1);
        chk("t3_count", DW'(count), 32'd4);
        for (int i = 0; i < 4; i++) begin
            pop_one();
            chk("t3_drain", IData, 32'(16'h0100 + i));
        end

        // 4: underflow keeps IData; simultaneous push+pop on empty
        step(1'b0, 1'b0, 1'b1, '0);
        press(17'h0_0005);
        pop_one();
        chk("t4_idata5", IData, 32'h5);
        step(1'b0, 1'b1, 1'b0, '0);
        chk("t4_unf", DW'(underflow), 32'd1);
        chk("t4_keep", IData, 32'h5);
        chk("t4_nodv", DW'(data_valid), 32'd0);
        step(1'b0, 1'b0, 1'b0, '0);
        step(1'b1, 1'b1, 1'b0, 17'h0_0077);
        chk("t4_count1", DW'(count), 32'd1);
        step(1'b0, 1'b0, 1'b0, '0);
        pop_one();

        // 5: push+pop while full, then wrap-around
        step(1'b0, 1'b0, 1'b1, '0);
        for (int i = 0; i < 4; i++) press(17'(16'h0200 + i));
        step(1'b1, 1'b1, 1'b0, 17'h0_0299);
        chk("t5_count", DW'(count), 32'd4);
        chk("t5_ovf", DW'(overflow), 32'd0);
        chk("t5_head", IData, 32'h0000_0200);
        step(1'b0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 3; i++) pop_one();
        pop_one();
        chk("t5_last", IData, 32'h0000_0299);
        for (int i = 0; i < 10; i++) begin
            press(17'(16'h0300 + i));
            pop_one();
            chk("t5_wrap", IData, 32'(16'h0300 + i));
        end

        // 6: flush with stickies set and concurrent push
        for (int i = 0; i < 5; i++) press(17'(16'h0400 + i));
        pop_one();
        step(1'b0, 0, 0, '0);
        pop_one(); pop_one(); pop_one(); pop_one();
        for (int i = 0; i < 3; i++) press(17'(16'h0500 + i));
        chk("t6_pre_cnt", DW'(count), 32'd3);
        chk("t6_pre_flags", DW'({overflow, underflow}), 32'd3);
        step(1'b1, 1'b0, 1'b1, 17'h0_0ABC);
        chk("t6_count", DW'(count), 32'd0);
        chk("t6_empty", DW'(empty), 32'd1);
        chk("t6_flags", DW'({overflow, underflow}), 32'd0);
        chk("t6_idata", IData, 32'h0000_0403);
        step(1'b0, 1'b0, 1'b0, '0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 24) == 0), 17'($urandom));
        end

        // Asynchronous reset mid-stream
        step(1'b0, 1'b0, 1'b0, '0);
        press(17'h0_0AAA);
        press(17'h0_0BBB);
        pop_one();
        #2 reset = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("rst_idata", IData, 32'h0);
        @(negedge clock);
        reset = 1'b1;
        step(1'b0, 1'b0, 1'b0, '0);
        pop_one();
        chk("rst_unf", DW'(underflow), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
